fpu_requester: RTL and testbench
================================

FPU_REQUESTER -- requirements
Module: fpu_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles a transaction may spend in SEND+WAIT before abort.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 op  in  4  FPU op code (0000 fadd .. 1000 fle), latched on accepted start.
REQ-007 a, b  in  32 each  operands, latched on accepted start.
REQ-008 busy  out  1  high in SEND, WAIT, ACK.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 error  out  1  one-cycle pulse coincident with done on abort or illegal op.
REQ-011 result  out  32  registered result, valid from done until next accepted start.
REQ-012 fpu_op  out  4  latched op, stable for the whole transaction.
REQ-013 fpu_in1, fpu_in2  out  32 each  latched a, b.
REQ-014 fpu_in1_stb, fpu_in2_stb  out  1 each  operand strobes to FPU.
REQ-015 fpu_in1_ack, fpu_in2_ack  in  1 each  operand accepts from FPU.
REQ-016 fpu_out  in  32  FPU result.
REQ-017 fpu_out_stb  in  1  FPU result valid.
REQ-018 fpu_out_ack  out  1  result accept to FPU.

Function
REQ-019 States SHALL be IDLE, SEND, WAIT, ACK; all outputs registered.
REQ-020 IDLE + start + op<=1000: latch op/a/b, clear timeout counter, go SEND; both stbs high next cycle.
REQ-021 IDLE + start + op>1000: no FPU strobe; next cycle done=1, error=1, result=0, stay IDLE.
REQ-022 start while busy SHALL be ignored; start in same cycle as done SHALL be accepted.
REQ-023 SEND: each stb held high with data stable until its ack sampled high; that stb low the following cycle; in1/in2 complete independently, either order or same cycle.
REQ-024 SEND -> WAIT on the edge where the last outstanding ack is sampled.
REQ-025 WAIT: on edge with fpu_out_stb high, capture fpu_out into result, go ACK; fpu_out_stb in SEND SHALL be ignored.
REQ-026 ACK: fpu_out_ack high exactly one cycle; then IDLE with done=1, error=0 that cycle.
REQ-027 fpu_out_ack SHALL be low in all other states.
REQ-028 Timeout counter increments each cycle in SEND or WAIT; on reaching TIMEOUT_CYCLES: all stbs low next cycle, go IDLE, done=1, error=1, result=0.
REQ-029 Timeout and completing handshake on same edge: completion wins.
REQ-030 Best-case latency (acks and fpu_out_stb returned combinationally the first cycle): start edge N -> stbs high N+1 -> out_ack high N+2 -> done N+3.

Reset
REQ-031 rst at any edge SHALL force IDLE; busy, done, error, all stbs, fpu_out_ack = 0; result, fpu_in1, fpu_in2 = 0; fpu_op = 0000; counter = 0.
REQ-032 rst mid-transaction SHALL drop stbs/ack next cycle with no done pulse; FPU recovery is the system's responsibility.

Verification
REQ-033 fadd a=0x3F800000 b=0x40000000, FPU acks immediately, out=0x40400000 -> done at N+3, result=0x40400000, error=0.
REQ-034 in2_ack 3 cycles before in1_ack -> fpu_in2_stb drops after its ack, fpu_in1_stb held, data stable, single out_ack pulse.
REQ-035 op=1111 -> no stb ever high, done=error=1 one cycle later, result=0.
REQ-036 FPU never raises fpu_out_stb, TIMEOUT_CYCLES=8 -> done=error=1 after 8 SEND+WAIT cycles, stbs low.
REQ-037 rst asserted during WAIT -> next cycle all outputs at reset values, no done; subsequent start completes normally.
REQ-038 start held high across two back-to-back transactions -> second accepted on done cycle, fpu_op updates only at acceptance.

Source files
------------

// File: rtl/fpu_requester.sv
// rtl/fpu_requester.sv - FPU operand/result handshake requester with timeout
//
// Accepts a start request carrying an op code and two operands, presents them
// to an FPU over two independent strobe/ack handshakes, waits for the FPU
// result, acknowledges it for one cycle and reports completion with a done
// pulse. Illegal op codes and transactions that spend TIMEOUT_CYCLES cycles
// in SEND+WAIT finish with done and error together and a zero result.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start, op, a, b                   request pulse, op code, operands
//   busy, done, error, result         status pulses and registered result
//   fpu_op, fpu_in1, fpu_in2          latched op and operands to the FPU
//   fpu_in1_stb, fpu_in1_ack          operand 1 handshake
//   fpu_in2_stb, fpu_in2_ack          operand 2 handshake
//   fpu_out, fpu_out_stb, fpu_out_ack result handshake

module fpu_requester #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic        fpu_in1_stb,
  output logic        fpu_in2_stb,
  input  logic        fpu_in1_ack,
  input  logic        fpu_in2_ack,
  input  logic [31:0] fpu_out,
  input  logic        fpu_out_stb,
  output logic        fpu_out_ack
);

  // One spare count above the limit: a SEND that completes exactly on the
  // limit still enters WAIT and increments once more before aborting.
  localparam int            CW            = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    OP_MAX        = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_ACK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          timed_out, abort;
  logic          busy_n, done_n, error_n;
  logic          in1_stb_n, in2_stb_n, out_ack_n;
  logic [31:0]   result_n, in1_n, in2_n;
  logic [3:0]    op_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cnt_inc   = cnt + CW'(1);
    timed_out = (cnt_inc >= TIMEOUT_LIMIT);
    abort     = 1'b0;
    done_n    = 1'b0;
    error_n   = 1'b0;
    out_ack_n = 1'b0;
    in1_stb_n = fpu_in1_stb;
    in2_stb_n = fpu_in2_stb;
    result_n  = result;
    in1_n     = fpu_in1;
    in2_n     = fpu_in2;
    op_n      = fpu_op;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (op <= OP_MAX) begin
            op_n      = op;
            in1_n     = a;
            in2_n     = b;
            cnt_n     = '0;
            in1_stb_n = 1'b1;
            in2_stb_n = 1'b1;
            state_n   = S_SEND;
          end else begin
            done_n   = 1'b1;
            error_n  = 1'b1;
            result_n = '0;
          end
        end
      end
      S_SEND: begin
        // Each strobe drops independently once its own ack is seen; acks on
        // an already-dropped strobe are ignored.
        in1_stb_n = fpu_in1_stb & ~fpu_in1_ack;
        in2_stb_n = fpu_in2_stb & ~fpu_in2_ack;
        cnt_n     = cnt_inc;
        if (!in1_stb_n && !in2_stb_n) begin
          state_n = S_WAIT;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_n = cnt_inc;
        if (fpu_out_stb) begin
          result_n  = fpu_out;
          out_ack_n = 1'b1;
          state_n   = S_ACK;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      S_ACK: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort) begin
      state_n   = S_IDLE;
      in1_stb_n = 1'b0;
      in2_stb_n = 1'b0;
      done_n    = 1'b1;
      error_n   = 1'b1;
      result_n  = '0;
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      result      <= '0;
      fpu_op      <= '0;
      fpu_in1     <= '0;
      fpu_in2     <= '0;
      fpu_in1_stb <= 1'b0;
      fpu_in2_stb <= 1'b0;
      fpu_out_ack <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
      result      <= result_n;
      fpu_op      <= op_n;
      fpu_in1     <= in1_n;
      fpu_in2     <= in2_n;
      fpu_in1_stb <= in1_stb_n;
      fpu_in2_stb <= in2_stb_n;
      fpu_out_ack <= out_ack_n;
    end
  end

endmodule

// File: tb/tb_fpu_requester.sv
// tb/tb_fpu_requester.sv - randomized scoreboard bench for fpu_requester
module tb_fpu_requester;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, error;
  logic [31:0] result;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_in1, fpu_in2;
  logic        fpu_in1_stb, fpu_in2_stb;
  logic        fpu_in1_ack = 1'b0;
  logic        fpu_in2_ack = 1'b0;
  logic [31:0] fpu_out = '0;
  logic        fpu_out_stb = 1'b0;
  logic        fpu_out_ack;

  fpu_requester #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .error(error), .result(result),
    .fpu_op(fpu_op), .fpu_in1(fpu_in1), .fpu_in2(fpu_in2),
    .fpu_in1_stb(fpu_in1_stb), .fpu_in2_stb(fpu_in2_stb),
    .fpu_in1_ack(fpu_in1_ack), .fpu_in2_ack(fpu_in2_ack),
    .fpu_out(fpu_out), .fpu_out_stb(fpu_out_stb), .fpu_out_ack(fpu_out_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Expected window of the transaction in flight (cycle numbers as seen after each edge).
  bit          cur_legal = 0;
  bit          cur_complete = 0;
  int          cur_n = 0;
  int          cur_dc = -1;
  int          cur_d1 = 0;
  int          cur_d2 = 0;
  logic [3:0]  exp_op = '0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  bit          mon_en = 0;
  int          rst_chk = -1;

  // FPU responder: ack delays, result delay, result value.
  int          d1 = 0, d2 = 0, dout = 0, c1 = 0, c2 = 0, wc = 0;
  logic [31:0] out_val = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (fpu_in1_stb) begin
      fpu_in1_ack = (c1 >= d1);
      c1++;
    end else fpu_in1_ack = 1'($urandom_range(0, 1));
    if (fpu_in2_stb) begin
      fpu_in2_ack = (c2 >= d2);
      c2++;
    end else fpu_in2_ack = 1'($urandom_range(0, 1));
    if (busy && !fpu_in1_stb && !fpu_in2_stb && !fpu_out_ack) begin
      fpu_out_stb = (wc >= dout);
      fpu_out = fpu_out_stb ? out_val : $urandom();
      wc++;
    end else if (fpu_out_ack) begin
      fpu_out_stb = 1'b0;
      fpu_out = $urandom();
    end else begin
      fpu_out_stb = 1'($urandom_range(0, 1));
      fpu_out = $urandom();
    end
  endtask

  // Outcome from cycle counts: s SEND cycles, w WAIT cycles, abort once T is reached
  // unless a handshake completes on that same cycle.
  task automatic begin_txn(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input int t1, input int t2, input int tw, input logic [31:0] ov);
    exp_t e;
    int n, s, w, lim;
    n = cyc + 1;
    start = 1'b1; op = o; a = av; b = bv;
    d1 = t1; d2 = t2; dout = tw; out_val = ov; c1 = 0; c2 = 0; wc = 0;
    cur_n = n; cur_d1 = t1; cur_d2 = t2; cur_complete = 0;
    if (o > 4'd8) begin
      cur_legal = 0; cur_dc = n; e.err = 1'b1; e.res = '0;
    end else begin
      cur_legal = 1; exp_op = o; exp_a = av; exp_b = bv;
      s = ((t1 > t2) ? t1 : t2) + 1;
      w = tw + 1;
      lim = (T > s + 1) ? T : s + 1;
      if (s > T) begin
        cur_dc = n + T; e.err = 1'b1; e.res = '0;
      end else if (s + w <= lim) begin
        cur_dc = n + s + w + 1; cur_complete = 1; e.err = 1'b0; e.res = ov;
      end else begin
        cur_dc = n + lim; e.err = 1'b1; e.res = '0;
      end
    end
    e.cyc = cur_dc;
    sb.push_back(e);
  endtask

  task automatic finish_txn(input bit hold);
    tick();
    while (cyc < cur_dc) begin
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a = $urandom();
      b = $urandom();
      tick();
    end
  endtask

  task automatic monitor_step();
    bit win, e_s1, e_s2, e_ack, e_done;
    exp_t e;
    win    = cur_legal && cyc >= cur_n && cyc < cur_dc;
    e_s1   = win && cyc <= cur_n + cur_d1;
    e_s2   = win && cyc <= cur_n + cur_d2;
    e_ack  = win && cur_complete && cyc == cur_dc - 1;
    e_done = (cyc == cur_dc);
    if (cyc == rst_chk) begin
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_error", 32'(error), 32'(0));
      check("rst_result", result, 32'(0));
      check("rst_fpu_op", 32'(fpu_op), 32'(0));
      check("rst_in1", fpu_in1, 32'(0));
      check("rst_in2", fpu_in2, 32'(0));
      check("rst_stb1", 32'(fpu_in1_stb), 32'(0));
      check("rst_stb2", 32'(fpu_in2_stb), 32'(0));
      check("rst_out_ack", 32'(fpu_out_ack), 32'(0));
    end
    check("busy", 32'(busy), 32'(win));
    check("in1_stb", 32'(fpu_in1_stb), 32'(e_s1));
    check("in2_stb", 32'(fpu_in2_stb), 32'(e_s2));
    check("out_ack", 32'(fpu_out_ack), 32'(e_ack));
    check("done", 32'(done), 32'(e_done));
    if (win) begin
      check("fpu_op", 32'(fpu_op), 32'(exp_op));
      check("fpu_in1", fpu_in1, exp_a);
      check("fpu_in2", fpu_in2, exp_b);
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done_unexpected cyc=%0d actual=1 expected=0", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("error", 32'(error), 32'(e.err));
        check("result", result, e.res);
      end
    end else begin
      check("error_no_done", 32'(error), 32'(0));
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL done_missing cyc=%0d actual=0 expected=1 at cyc %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) monitor_step();
  end

  logic [3:0] r_op;
  int r_t1, r_t2, r_tw, r_gap;

  initial begin
    tick();
    mon_en = 1;
    rst_chk = cyc + 1;
    tick();
    rst = 1'b0;

    // fadd 1.0 + 2.0, immediate FPU
    begin_txn(4'd0, 32'h3F800000, 32'h40000000, 0, 0, 0, 32'h40400000); finish_txn(0);
    // in2 acked three cycles before in1
    begin_txn(4'd1, $urandom(), $urandom(), 3, 0, 1, $urandom()); finish_txn(0);
    // illegal op
    begin_txn(4'hF, $urandom(), $urandom(), 0, 0, 0, $urandom()); finish_txn(0);
    // FPU never returns a result
    begin_txn(4'd2, $urandom(), $urandom(), 0, 0, 100, $urandom()); finish_txn(0);
    // timeout boundaries: SEND ends on the limit, WAIT ends on the limit
    begin_txn(4'd3, $urandom(), $urandom(), 7, 2, 0, $urandom()); finish_txn(0);
    begin_txn(4'd4, $urandom(), $urandom(), 2, 7, 1, $urandom()); finish_txn(0);
    begin_txn(4'd5, $urandom(), $urandom(), 0, 0, 6, $urandom()); finish_txn(0);
    begin_txn(4'd6, $urandom(), $urandom(), 0, 0, 7, $urandom()); finish_txn(0);
    begin_txn(4'd7, $urandom(), $urandom(), 8, 0, 0, $urandom()); finish_txn(0);

    // reset during WAIT
    begin_txn(4'd8, $urandom(), $urandom(), 0, 0, 100, $urandom());
    tick();
    tick();
    rst = 1'b1; start = 1'b0;
    sb.delete();
    cur_legal = 0; cur_dc = -1;
    rst_chk = cyc + 1;
    tick();
    rst = 1'b0;

    // start held high across back-to-back transactions
    begin_txn(4'd3, $urandom(), $urandom(), 0, 0, 0, $urandom()); finish_txn(1);
    begin_txn(4'd4, $urandom(), $urandom(), 1, 2, 0, $urandom()); finish_txn(1);
    start = 1'b0;
    tick();

    for (int i = 0; i < 60; i++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      r_t1 = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) r_t1 = $urandom_range(0, 9);
      r_t2 = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) r_t2 = $urandom_range(0, 9);
      r_tw = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) r_tw = $urandom_range(0, 10);
      begin_txn(r_op, $urandom(), $urandom(), r_t1, r_t2, r_tw, $urandom());
      finish_txn($urandom_range(0, 2) == 0);
      r_gap = $urandom_range(0, 2);
      for (int g = 0; g < r_gap; g++) begin
        start = 1'b0;
        tick();
      end
    end

    start = 1'b0;
    tick();
    tick();
    tick();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
